fft8_frame_collector: RTL



---
 rtl/fft8_pkg.sv | 27 ++
 rtl/fft8_frame_collector_if.sv | 33 +++
 rtl/fft8_frame_bank.sv | 22 ++
 rtl/fft8_frame_collector.sv | 87 ++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// Shared definitions for the fft8 datapath: frame geometry, FP16 field slices
// and the complex sample type.
package fft8_pkg;

  localparam int FFT_N  = 8;
  localparam int LOG2N  = 3;
  localparam int DW     = 32;
  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  typedef struct packed {
    logic [RE_MSB-RE_LSB:0] re;
    logic [IM_MSB-IM_LSB:0] im;
  } cplx_fp16_t;

  typedef enum logic {
    BANK_FILLING = 1'b0,
    BANK_FULL    = 1'b1
  } bank_state_t;

  function automatic logic [DW-1:0] pack_cplx(input logic [15:0] re, input logic [15:0] im);
    return {re, im};
  endfunction

endpackage

// File: rtl/fft8_frame_collector_if.sv
// Sample stream in, parallel frame out; slave is the collector's view.
interface fft8_frame_collector_if #(
  parameter int DW = 32
);

  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          frame_valid;
  logic          frame_ready;
  logic [DW-1:0] frame_0;
  logic [DW-1:0] frame_1;
  logic [DW-1:0] frame_2;
  logic [DW-1:0] frame_3;
  logic [DW-1:0] frame_4;
  logic [DW-1:0] frame_5;
  logic [DW-1:0] frame_6;
  logic [DW-1:0] frame_7;
  logic [2:0]    frame_idx;

  modport slave (
    input  s_valid, s_data, frame_ready,
    output s_ready, frame_valid, frame_idx,
           frame_0, frame_1, frame_2, frame_3, frame_4, frame_5, frame_6, frame_7
  );

  modport master (
    output s_valid, s_data, frame_ready,
    input  s_ready, frame_valid, frame_idx,
           frame_0, frame_1, frame_2, frame_3, frame_4, frame_5, frame_6, frame_7
  );

endinterface

// File: rtl/fft8_frame_bank.sv
// N x DW register bank: one indexed write port, all words visible in parallel.
module fft8_frame_bank #(
  parameter int DW = 32,
  parameter int N  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [fft8_pkg::LOG2N-1:0]   widx,
  input  logic [DW-1:0]                wdata,
  output logic [DW-1:0]                q [N]
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) q[i] <= '0;
    end else if (we) begin
      q[widx] <= wdata;
    end
  end

endmodule

// File: rtl/fft8_frame_collector.sv
// Ping-pong frame collector: assembles 8 serial samples per frame into one of
// two banks and presents the oldest full bank as eight parallel words.
module fft8_frame_collector #(
  parameter int DW = 32,
  parameter int N  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fft8_frame_collector_if.slave   bus
);

  import fft8_pkg::*;

  logic [LOG2N-1:0] wr_ptr;
  logic             wr_bank;
  logic             rd_bank;
  bank_state_t      bank_st [2];

  logic accept;
  logic consume;
  logic complete;

  logic [DW-1:0] q0  [N];
  logic [DW-1:0] q1  [N];
  logic [DW-1:0] sel [N];

  assign bus.s_ready     = (bank_st[wr_bank] == BANK_FILLING);
  assign bus.frame_valid = (bank_st[rd_bank] == BANK_FULL);
  assign bus.frame_idx   = wr_ptr;

  assign accept   = bus.s_valid && bus.s_ready;
  assign consume  = bus.frame_valid && bus.frame_ready;
  assign complete = accept && (wr_ptr == 3'd7);

  // Completion targets a FILLING bank and consumption a FULL one, so when both
  // fire in one cycle they always update different banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) bank_st[i] <= BANK_FILLING;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 3'd1;
      if (complete) begin
        bank_st[wr_bank] <= BANK_FULL;
        wr_bank          <= ~wr_bank;
      end
      if (consume) begin
        bank_st[rd_bank] <= BANK_FILLING;
        rd_bank          <= ~rd_bank;
      end
    end
  end

  fft8_frame_bank #(.DW(DW), .N(N)) u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept && !wr_bank),
    .widx  (wr_ptr),
    .wdata (bus.s_data),
    .q     (q0)
  );

  fft8_frame_bank #(.DW(DW), .N(N)) u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept && wr_bank),
    .widx  (wr_ptr),
    .wdata (bus.s_data),
    .q     (q1)
  );

  always_comb begin
    for (int unsigned k = 0; k < N; k++) sel[k] = rd_bank ? q1[k] : q0[k];
  end

  assign bus.frame_0 = sel[0];
  assign bus.frame_1 = sel[1];
  assign bus.frame_2 = sel[2];
  assign bus.frame_3 = sel[3];
  assign bus.frame_4 = sel[4];
  assign bus.frame_5 = sel[5];
  assign bus.frame_6 = sel[6];
  assign bus.frame_7 = sel[7];

endmodule
